mouse_pos_sync: RTL
===================

Name: mouse_pos_sync

Overview:
Parametrised multi-channel synchroniser for mouse position buses crossing from the PS/2-mouse clock domain into the system clock domain. Each channel passes through an N-stage flop chain. A cross-channel stability filter then publishes a snapshot only after every channel has held its value for a programmable number of cycles. This removes multi-bit incoherence, where some bits of a bus arrive a cycle before others. Sits between the mouse controller and the draw/game logic; replaces the fixed 12-bit x/y two-stage buffer.

Parameters:
WIDTH, 12, bit width of one position channel
CHANNELS, 2, number of channels (channel 0 = x, channel 1 = y)
SYNC_STAGES, 2, flop stages per synchroniser chain (minimum 2)
STABLE_CYCLES, 3, consecutive equal cycles required before publishing (minimum 1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset (0 = reset)
freeze  input  1  synchronous to clk; 1 = hold pos_out and suppress updates
pos_in  input  CHANNELS*WIDTH  asynchronous positions; channel c at [c*WIDTH +: WIDTH]
pos_out  output  CHANNELS*WIDTH  published coherent snapshot, same packing
pos_update  output  1  one-cycle pulse, high in the cycle pos_out takes a new value
stable  output  1  all channels stable for STABLE_CYCLES cycles

Behaviour:
- Reset: rst low asynchronously clears all flops: chains, previous-value register, counter, pos_out = 0, pos_update = 0, stable = 0. Deassertion of rst is synchronised to clk by the top-level reset synchroniser.
- Synchroniser chain, per channel: s[0] <= pos_in_c; s[k] <= s[k-1]. Synchronised value sync_c = s[SYNC_STAGES-1].
- Previous register: prev_c <= sync_c every cycle.
- all_eq = AND over all channels of (sync_c == prev_c). This is a combinational compare of registered values.
- Counter cnt, width $clog2(STABLE_CYCLES+1):
  - !all_eq -> cnt <= 0.
  - Else cnt < STABLE_CYCLES -> cnt <= cnt+1.
  - Else hold (saturate at STABLE_CYCLES).
- stable = (cnt == STABLE_CYCLES). It is decoded from the cnt register with no extra flop.
- Publish: on each edge, if stable && !freeze && (prev != pos_out, compared over the full bus):
  - pos_out <= prev.
  - pos_update <= 1.
  - Otherwise pos_out holds and pos_update <= 0.
- Latency: for a single step on pos_in set up before edge 1, with inputs then static:
  - sync shows the new value at edge S (S = SYNC_STAGES).
  - cnt = 0 at edge S+1, cnt = STABLE_CYCLES at edge S+1+K (K = STABLE_CYCLES).
  - pos_out and pos_update change at edge S+2+K. Default parameters give 7 edges.
- Any channel changing restarts the counter for all channels, so a snapshot never mixes old x with new y.
- Input toggling at least once every STABLE_CYCLES+1 cycles: stable never asserts and pos_out holds indefinitely.
- Identical value re-stabilising (a glitch that returns to the published value): stable asserts, but there is no pos_update because prev == pos_out.
- freeze: the chain and counter keep running during freeze. On the edge after freeze falls, if stable is high and the value differs, publish immediately.
- pos_update never stays high for two consecutive cycles unless the value changed twice. Two consecutive pulses are impossible for STABLE_CYCLES >= 1.
- Reset mid-operation: rst low clears everything within the same cycle, including a pending publish. After release, the first publish follows the full latency, and only if the inputs are nonzero (pos_out is already 0).
- Elaboration error (assert in an initial block / $error) if SYNC_STAGES < 2, STABLE_CYCLES < 1, CHANNELS < 1 or WIDTH < 1.

Decomposition:
- Package mouse_sync_pkg:
  - POS_WIDTH = 12, POS_CHANNELS = 2, DEF_SYNC_STAGES = 2, DEF_STABLE_CYCLES = 3.
  - typedef logic [POS_WIDTH-1:0] pos_t.
- Sub-module sync_chain (params WIDTH, STAGES; ports clk, rst, d, q): async active-low reset flop chain, instantiated once per channel through a generate loop.
- Top level holds prev, the comparator, the counter and the publish register.

Test Plan:
1. Reset: rst low with pos_in = 0xFFF/0xFFF -> pos_out = 0, pos_update = 0, stable = 0 throughout. Release, then wait -> pos_out = 0xFFF/0xFFF at edge 7, with a single pos_update pulse.
2. Step: x = 100, y = 200 applied before edge 1 -> pos_out = {200,100} exactly at edge 7, pos_update high for one cycle, stable high from edge 6.
3. Incoherence: x = 100 at edge 1, y = 200 at edge 3 -> the counter restarts, no intermediate {0,100} is published, {200,100} appears at edge 9.
4. Glitch: x toggles 5/6 every 2 cycles for 50 cycles -> no pos_update. Then hold 6 -> one update to 6.
5. Freeze: freeze = 1 while a step to x = 300 stabilises -> pos_out is unchanged and stable = 1. Freeze falls -> pos_out = 300 and pos_update on the next edge.
6. Parameters SYNC_STAGES = 3, STABLE_CYCLES = 1, CHANNELS = 3, WIDTH = 8. Step all channels to 0xAA -> update at edge 6. Assert rst mid-count -> the publish is cancelled and outputs are 0 immediately.

Source files
------------

// File: rtl/mouse_sync_pkg.sv
// -----------------------------------------------------------------------------
// mouse_sync_pkg
// Shared constants and types for the mouse position synchroniser.
//   POS_WIDTH / POS_CHANNELS   : default bus geometry (12-bit x and y)
//   DEF_SYNC_STAGES            : default synchroniser depth
//   DEF_STABLE_CYCLES          : default settle time before a snapshot is published
//   pos_t                      : one position channel at the default width
// -----------------------------------------------------------------------------
package mouse_sync_pkg;

    localparam int POS_WIDTH         = 12;
    localparam int POS_CHANNELS      = 2;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 3;

    typedef logic [POS_WIDTH-1:0] pos_t;

endpackage

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Plain multi-flop synchroniser for one bus channel. It gives no coherence
// guarantee across bits; coherence is handled by the caller.
//   clk  : destination clock
//   rst  : asynchronous active-low reset
//   d    : asynchronous input
//   q    : synchronised output, STAGES clocks after d was sampled
// -----------------------------------------------------------------------------
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Stage 0 is the metastability-catching flop; stage STAGES-1 drives q.
    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: every stage is reset, so after reset the chain reports zero
            // rather than whatever the flops powered up with.
            stage_q <= '0;
        end else begin
            // NOTE: non-blocking assignment makes each stage take the value its
            // neighbour held before the edge, so the data really shifts one flop per clock.
            stage_q <= {stage_q[STAGES-2:0], d};
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/mouse_pos_sync.sv
// -----------------------------------------------------------------------------
// mouse_pos_sync
// Moves mouse position buses from the PS/2 clock domain into clk. Each channel
// goes through its own sync_chain. A snapshot is published only once every
// channel has held still for STABLE_CYCLES consecutive cycles, so bits that
// arrive a cycle apart never produce a mixed value.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   freeze     : 1 = hold pos_out (the filter keeps running underneath)
//   pos_in     : asynchronous positions, channel c at [c*WIDTH +: WIDTH]
//   pos_out    : last published coherent snapshot, same packing
//   pos_update : one-cycle pulse in the cycle pos_out takes a new value
//   stable     : all channels unchanged for STABLE_CYCLES cycles
// -----------------------------------------------------------------------------
module mouse_pos_sync
    import mouse_sync_pkg::*;
#(
    parameter int WIDTH         = POS_WIDTH,
    parameter int CHANNELS      = POS_CHANNELS,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic [CHANNELS*WIDTH-1:0] pos_in,
    output logic [CHANNELS*WIDTH-1:0] pos_out,
    output logic                      pos_update,
    output logic                      stable
);

    localparam int BUS_W = CHANNELS * WIDTH;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    // Reject geometries the filter cannot work with.
    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("mouse_pos_sync: SYNC_STAGES must be at least 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("mouse_pos_sync: STABLE_CYCLES must be at least 1");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("mouse_pos_sync: CHANNELS must be at least 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("mouse_pos_sync: WIDTH must be at least 1");
    end

    logic [BUS_W-1:0]    sync_bus;
    logic [CHANNELS-1:0] ch_eq;
    logic                all_eq;

    logic [BUS_W-1:0]    prev_q;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [BUS_W-1:0]    pos_out_q,    pos_out_d;
    logic                pos_update_q, pos_update_d;

    // One synchroniser and one change detector per channel.
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        sync_chain #(
            .WIDTH  (WIDTH),
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (pos_in[ch*WIDTH +: WIDTH]),
            .q   (sync_bus[ch*WIDTH +: WIDTH])
        );

        assign ch_eq[ch] = (sync_bus[ch*WIDTH +: WIDTH] == prev_q[ch*WIDTH +: WIDTH]);
    end

    // Any single channel moving restarts the settle count for all of them.
    assign all_eq = &ch_eq;
    assign stable = (cnt_q == CNT_MAX);

    always_comb begin
        // NOTE: every variable gets its default before any condition, so no path
        // leaves one unassigned and no latch is inferred.
        cnt_d        = cnt_q;
        pos_out_d    = pos_out_q;
        pos_update_d = 1'b0;

        if (!all_eq) begin
            cnt_d = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // prev_q, not sync_bus, is published: it is the value the whole
        // stable window was measured on. Re-settling onto the value already
        // shown gives no pulse.
        if (stable && !freeze && (prev_q != pos_out_q)) begin
            pos_out_d    = prev_q;
            pos_update_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q       <= '0;
            cnt_q        <= '0;
            pos_out_q    <= '0;
            pos_update_q <= 1'b0;
        end else begin
            prev_q       <= sync_bus;
            cnt_q        <= cnt_d;
            pos_out_q    <= pos_out_d;
            pos_update_q <= pos_update_d;
        end
    end

    assign pos_out    = pos_out_q;
    assign pos_update = pos_update_q;

endmodule
